// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// Operand forwarding and load-use hazard detection for a 5-stage pipeline.
// Keeps its own shadow copy of the EX/MEM/WB destination tags, generates
// per-operand forwarding selects, muxes the EX operands, raises a one-cycle
// load-use stall (inserting a bubble into EX), and counts stall cycles with
// a saturating counter.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   id_valid          valid instruction in ID
//   id_rs             NUM_SRC source register addresses, operand i at [i*REG_AW +: REG_AW]
//   id_rd             destination register of the ID instruction
//   id_reg_write      ID instruction writes the register file
//   id_mem_read       ID instruction is a load
//   ex_data           NUM_SRC operand values from the ID/EX register
//   mem_data          ALU result held in EX/MEM
//   wb_data           writeback value held in MEM/WB
//   flush             kill the ID instruction
//   ext_stall         global pipeline freeze; all state holds
//   operand           forwarded EX operands
//   fwd_sel           per-operand select: 00 ID/EX, 01 EX/MEM, 10 MEM/WB
//   load_use_stall    hold PC and IF/ID this cycle
//   stall_count       saturating count of load-use stall cycles

module fwd_hazard_unit #(
   parameter int DATA_W  = 32,
   parameter int NUM_SRC = 2,
   parameter int REG_AW  = 5,
   parameter int CNT_W   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        id_valid,
   input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
   input  logic [REG_AW-1:0]           id_rd,
   input  logic                        id_reg_write,
   input  logic                        id_mem_read,
   input  logic [NUM_SRC*DATA_W-1:0]   ex_data,
   input  logic [DATA_W-1:0]           mem_data,
   input  logic [DATA_W-1:0]           wb_data,
   input  logic                        flush,
   input  logic                        ext_stall,
   output logic [NUM_SRC*DATA_W-1:0]   operand,
   output logic [NUM_SRC*2-1:0]        fwd_sel,
   output logic                        load_use_stall,
   output logic [CNT_W-1:0]            stall_count
);

   localparam logic [1:0] SEL_EX  = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_WB  = 2'b10;

   // Shadow pipeline state
   logic                       ex_valid;
   logic [NUM_SRC*REG_AW-1:0]  ex_rs;
   logic [REG_AW-1:0]          ex_rd;
   logic                       ex_reg_write;
   logic                       ex_mem_read;

   logic                       mem_valid;
   logic [REG_AW-1:0]          mem_rd;
   logic                       mem_reg_write;
   logic                       mem_mem_read;

   logic                       wb_valid;
   logic [REG_AW-1:0]          wb_rd;
   logic                       wb_reg_write;

   logic                       mem_fwd_ok;
   logic                       wb_fwd_ok;
   logic                       hazard;
   logic                       rs_match;
   logic                       ex_bubble;

   // A load result is not yet available in EX/MEM, so MEM never forwards a load.
   assign mem_fwd_ok = mem_valid & mem_reg_write & (mem_rd != '0) & ~mem_mem_read;
   assign wb_fwd_ok  = wb_valid & wb_reg_write & (wb_rd != '0);

   always_comb begin
      logic [REG_AW-1:0] rs_i;
      logic [1:0]        sel;
      fwd_sel = '0;
      operand = '0;
      rs_i    = '0;
      sel     = SEL_EX;
      for (int i = 0; i < NUM_SRC; i++) begin
         rs_i = ex_rs[i*REG_AW +: REG_AW];
         sel  = SEL_EX;
         if (ex_valid) begin
            if (mem_fwd_ok && (mem_rd == rs_i))
               sel = SEL_MEM;
            else if (wb_fwd_ok && (wb_rd == rs_i))
               sel = SEL_WB;
         end
         fwd_sel[i*2 +: 2] = sel;
         case (sel)
            SEL_EX:  operand[i*DATA_W +: DATA_W] = ex_data[i*DATA_W +: DATA_W];
            SEL_MEM: operand[i*DATA_W +: DATA_W] = mem_data;
            SEL_WB:  operand[i*DATA_W +: DATA_W] = wb_data;
            default: operand[i*DATA_W +: DATA_W] = '0;
         endcase
      end
   end

   always_comb begin
      rs_match = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (id_rs[i*REG_AW +: REG_AW] == ex_rd)
            rs_match = 1'b1;
      end
   end

   assign hazard         = id_valid & ex_valid & ex_mem_read & ex_reg_write &
                           (ex_rd != '0) & rs_match;
   assign load_use_stall = hazard & ~flush;
   assign ex_bubble      = flush | load_use_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ex_rs         <= '0;
         ex_rd         <= '0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         mem_valid     <= 1'b0;
         mem_rd        <= '0;
         mem_reg_write <= 1'b0;
         mem_mem_read  <= 1'b0;
         wb_valid      <= 1'b0;
         wb_rd         <= '0;
         wb_reg_write  <= 1'b0;
         stall_count   <= '0;
      end else if (!ext_stall) begin
         ex_valid      <= id_valid & ~ex_bubble;
         ex_rs         <= id_rs;
         ex_rd         <= id_rd;
         ex_reg_write  <= id_reg_write;
         ex_mem_read   <= id_mem_read;
         mem_valid     <= ex_valid;
         mem_rd        <= ex_rd;
         mem_reg_write <= ex_reg_write;
         mem_mem_read  <= ex_mem_read;
         wb_valid      <= mem_valid;
         wb_rd         <= mem_rd;
         wb_reg_write  <= mem_reg_write;
         if (load_use_stall && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [9:0]  id_rs;
   logic [4:0]  id_rd;
   logic        id_reg_write;
   logic        id_mem_read;
   logic [63:0] ex_data;
   logic [31:0] mem_data;
   logic [31:0] wb_data;
   logic        flush;
   logic        ext_stall;
   logic [63:0] operand;
   logic [3:0]  fwd_sel;
   logic        load_use_stall;
   logic [15:0] stall_count;

   logic [63:0] operand_s;
   logic [3:0]  fwd_sel_s;
   logic        load_use_stall_s;
   logic [1:0]  stall_count_s;

   int passed;
   int total;

   fwd_hazard_unit dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_data(ex_data),
      .mem_data(mem_data), .wb_data(wb_data), .flush(flush), .ext_stall(ext_stall),
      .operand(operand), .fwd_sel(fwd_sel), .load_use_stall(load_use_stall),
      .stall_count(stall_count)
   );

   fwd_hazard_unit #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_data(ex_data),
      .mem_data(mem_data), .wb_data(wb_data), .flush(flush), .ext_stall(ext_stall),
      .operand(operand_s), .fwd_sel(fwd_sel_s), .load_use_stall(load_use_stall_s),
      .stall_count(stall_count_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [4:0] rd, input logic rw, input logic mr);
      id_valid     = v;
      id_rs        = {rs1, rs0};
      id_rd        = rd;
      id_reg_write = rw;
      id_mem_read  = mr;
   endtask

   task automatic set_idle();
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      set_idle();
      flush     = 1'b0;
      ext_stall = 1'b0;
      rst       = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      flush     = 1'b0;
      ext_stall = 1'b0;
      ex_data   = {32'hBBBB_0002, 32'hAAAA_0001};
      mem_data  = 32'h11;
      wb_data   = 32'h22;
      set_id(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1);
      step();
      step();
      total++;
      if (fwd_sel !== 4'b0000) $display("FAIL reset_fwd_sel: got %b expected 0000", fwd_sel);
      else passed++;
      total++;
      if (operand[31:0] !== 32'hAAAA_0001) $display("FAIL reset_operand0: got %h expected aaaa0001", operand[31:0]);
      else passed++;
      total++;
      if (load_use_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", load_use_stall);
      else passed++;
      total++;
      if (stall_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", stall_count);
      else passed++;
      do_reset();
   endtask

   task automatic test_mem_priority();
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);   // ADD x5
      step();
      set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0);   // ADD x5
      step();
      set_id(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0);   // consumer rs0=x5
      step();
      set_idle();
      #1;
      total++;
      if (fwd_sel !== 4'b0001) $display("FAIL mem_prio_sel: got %b expected 0001", fwd_sel);
      else passed++;
      total++;
      if (operand !== {32'hBBBB_0002, 32'h0000_0011}) $display("FAIL mem_prio_operand: got %h expected bbbb000200000011", operand);
      else passed++;

      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);   // ADD x0
      step();
      set_id(1'b1, 5'd3, 5'd4, 5'd0, 1'b1, 1'b0);   // ADD x0
      step();
      set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);   // consumer of x0
      step();
      set_idle();
      #1;
      total++;
      if (fwd_sel !== 4'b0000) $display("FAIL x0_sel: got %b expected 0000", fwd_sel);
      else passed++;
      total++;
      if (operand[31:0] !== 32'hAAAA_0001) $display("FAIL x0_operand0: got %h expected aaaa0001", operand[31:0]);
      else passed++;
   endtask

   task automatic test_wb_forward();
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1);   // LW x6
      step();
      set_id(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0);   // independent ADD x8
      step();
      set_id(1'b1, 5'd6, 5'd0, 5'd9, 1'b1, 1'b0);   // consumer rs0=x6
      #1;
      total++;
      if (load_use_stall !== 1'b0) $display("FAIL wb_fwd_nostall: got %b expected 0", load_use_stall);
      else passed++;
      step();
      set_idle();
      #1;
      total++;
      if (fwd_sel !== 4'b0010) $display("FAIL wb_fwd_sel: got %b expected 0010", fwd_sel);
      else passed++;
      total++;
      if (operand[31:0] !== 32'h0000_0022) $display("FAIL wb_fwd_operand0: got %h expected 00000022", operand[31:0]);
      else passed++;
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);   // LW x7
      step();
      set_id(1'b1, 5'd3, 5'd7, 5'd9, 1'b1, 1'b0);   // ADD rs1=x7
      #1;
      total++;
      if (load_use_stall !== 1'b1) $display("FAIL lu_stall_n: got %b expected 1", load_use_stall);
      else passed++;
      step();
      total++;
      if (load_use_stall !== 1'b0) $display("FAIL lu_stall_n1: got %b expected 0", load_use_stall);
      else passed++;
      total++;
      if (stall_count !== 16'd1) $display("FAIL lu_count: got %0d expected 1", stall_count);
      else passed++;
      step();
      set_idle();
      #1;
      total++;
      if (fwd_sel !== 4'b1000) $display("FAIL lu_fwd_sel: got %b expected 1000", fwd_sel);
      else passed++;
      total++;
      if (operand !== {32'h0000_0022, 32'hAAAA_0001}) $display("FAIL lu_operand: got %h expected 00000022aaaa0001", operand);
      else passed++;
      total++;
      if (stall_count !== 16'd1) $display("FAIL lu_count_hold: got %0d expected 1", stall_count);
      else passed++;
   endtask

   task automatic test_flush();
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);   // LW x7
      step();
      set_id(1'b1, 5'd3, 5'd7, 5'd9, 1'b1, 1'b1);   // LW x9 reading x7, flushed
      flush = 1'b1;
      #1;
      total++;
      if (load_use_stall !== 1'b0) $display("FAIL flush_stall: got %b expected 0", load_use_stall);
      else passed++;
      step();
      flush = 1'b0;
      set_id(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0);  // would stall if x9 load reached EX
      #1;
      total++;
      if (load_use_stall !== 1'b0) $display("FAIL flush_bubble: got %b expected 0", load_use_stall);
      else passed++;
      total++;
      if (stall_count !== 16'd0) $display("FAIL flush_count: got %0d expected 0", stall_count);
      else passed++;
      set_idle();
   endtask

   task automatic test_ext_stall();
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);   // LW x7
      step();
      set_id(1'b1, 5'd3, 5'd7, 5'd9, 1'b1, 1'b0);
      ext_stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++;
         if (load_use_stall !== 1'b1 || stall_count !== 16'd0)
            $display("FAIL ext_hold_%0d: got stall=%b count=%0d expected stall=1 count=0", c, load_use_stall, stall_count);
         else passed++;
         step();
      end
      ext_stall = 1'b0;
      #1;
      total++;
      if (load_use_stall !== 1'b1 || stall_count !== 16'd0)
         $display("FAIL ext_release_pre: got stall=%b count=%0d expected stall=1 count=0", load_use_stall, stall_count);
      else passed++;
      step();
      total++;
      if (load_use_stall !== 1'b0 || stall_count !== 16'd1)
         $display("FAIL ext_release_post: got stall=%b count=%0d expected stall=0 count=1", load_use_stall, stall_count);
      else passed++;
      set_idle();
   endtask

   task automatic test_saturation();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
         step();
         set_id(1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 1'b0);
         step();
         set_idle();
         step();
         if (k == 2) begin
            total++;
            if (stall_count_s !== 2'd3) $display("FAIL sat_reach: got %0d expected 3", stall_count_s);
            else passed++;
         end
      end
      total++;
      if (stall_count_s !== 2'd3) $display("FAIL sat_nowrap: got %0d expected 3", stall_count_s);
      else passed++;
      total++;
      if (stall_count !== 16'd5) $display("FAIL sat_wide_count: got %0d expected 5", stall_count);
      else passed++;
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 1'b0);
      #1;
      total++;
      if (load_use_stall !== 1'b1 || stall_count !== 16'd1)
         $display("FAIL mid_pre: got stall=%b count=%0d expected stall=1 count=1", load_use_stall, stall_count);
      else passed++;
      #1;
      rst = 1'b1;
      #1;
      total++;
      if (load_use_stall !== 1'b0 || stall_count !== 16'd0)
         $display("FAIL mid_reset: got stall=%b count=%0d expected stall=0 count=0", load_use_stall, stall_count);
      else passed++;
      step();
      rst = 1'b0;
      set_idle();
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_mem_priority();
      test_wb_forward();
      test_load_use();
      test_flush();
      test_ext_stall();
      test_saturation();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
